bram_port_arbiter: RTL

- Shares one port of the byte-enabled dual-port block RAM between two requesters (r0, r1), e.g. a CPU data port and a UART loader.
- Arbitrates round-robin and converts byte-addressed byte/half/word accesses into RAM word address, byte-lane write enables, lane-replicated write data and right-aligned zero-extended read data.
- Sits directly in front of one RAM port; the other RAM port stays free.

---
 rtl/bram_port_arbiter_if.sv | 46 ++++
 rtl/bram_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and one RAM port.
// slave: arbiter side. master: requester/RAM side (testbench or system).
interface bram_port_arbiter_if #(
    parameter int ADDRESS_BITWIDTH = 16
);
    logic                        r0_req;
    logic                        r0_write;
    logic [ADDRESS_BITWIDTH+1:0] r0_address;
    logic [1:0]                  r0_size;
    logic [31:0]                 r0_data_in;
    logic [31:0]                 r0_data_out;
    logic                        r0_ack;
    logic                        r0_error;

    logic                        r1_req;
    logic                        r1_write;
    logic [ADDRESS_BITWIDTH+1:0] r1_address;
    logic [1:0]                  r1_size;
    logic [31:0]                 r1_data_in;
    logic [31:0]                 r1_data_out;
    logic                        r1_ack;
    logic                        r1_error;

    logic [3:0]                  ram_write_enable;
    logic [ADDRESS_BITWIDTH-1:0] ram_address;
    logic [31:0]                 ram_data_in;
    logic [31:0]                 ram_data_out;

    modport slave (
        input  r0_req, r0_write, r0_address, r0_size, r0_data_in,
        output r0_data_out, r0_ack, r0_error,
        input  r1_req, r1_write, r1_address, r1_size, r1_data_in,
        output r1_data_out, r1_ack, r1_error,
        output ram_write_enable, ram_address, ram_data_in,
        input  ram_data_out
    );

    modport master (
        output r0_req, r0_write, r0_address, r0_size, r0_data_in,
        input  r0_data_out, r0_ack, r0_error,
        output r1_req, r1_write, r1_address, r1_size, r1_data_in,
        input  r1_data_out, r1_ack, r1_error,
        input  ram_write_enable, ram_address, ram_data_in,
        output ram_data_out
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one byte-enabled BRAM port by two requesters.
// Ports: clk, rst (async, active high), bus (slave modport: r0/r1 + RAM).
module bram_port_arbiter #(
    parameter int ADDRESS_BITWIDTH = 16,
    parameter int DATA_BITWIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_port_arbiter_if.slave   bus
);
    localparam int AW = ADDRESS_BITWIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_grant;
    logic                     r_last_grant;
    logic                     r_error;
    logic [DATA_BITWIDTH-1:0] r_data0;
    logic [DATA_BITWIDTH-1:0] r_data1;

    logic                     w_any;
    logic                     w_sel;
    logic                     w_port;
    logic                     w_write;
    logic [AW-1:0]            w_addr;
    logic [1:0]               w_size;
    logic [DATA_BITWIDTH-1:0] w_din;
    logic [DATA_BITWIDTH-1:0] w_wdata;
    logic [3:0]               w_lanes;
    logic                     w_legal;
    logic [DATA_BITWIDTH-1:0] w_shift;
    logic [DATA_BITWIDTH-1:0] w_rdata;

    // In IDLE the fresh arbitration result drives the RAM; afterwards the
    // registered grant keeps the (stable) request of the winner selected.
    always_comb begin
        w_any = bus.r0_req | bus.r1_req;
        if (bus.r0_req && bus.r1_req)
            w_sel = ~r_last_grant;
        else
            w_sel = bus.r1_req;
        w_port = (r_state == IDLE) ? w_sel : r_grant;
        if (w_port) begin
            w_write = bus.r1_write;
            w_addr  = bus.r1_address;
            w_size  = bus.r1_size;
            w_din   = bus.r1_data_in;
        end else begin
            w_write = bus.r0_write;
            w_addr  = bus.r0_address;
            w_size  = bus.r0_size;
            w_din   = bus.r0_data_in;
        end
    end

    always_comb begin
        w_lanes = 4'b1111;
        w_wdata = w_din;
        w_legal = 1'b0;
        case (w_size)
            2'b00: begin
                w_lanes = 4'b0001 << w_addr[1:0];
                w_wdata = {4{w_din[7:0]}};
                w_legal = 1'b1;
            end
            2'b01: begin
                w_lanes = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_din[15:0]}};
                w_legal = ~w_addr[0];
            end
            2'b10: w_legal = (w_addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // Legal accesses are aligned, so a byte-lane shift also serves half/word.
    always_comb begin
        w_shift = bus.ram_data_out >> {w_addr[1:0], 3'b000};
        case (w_size)
            2'b00:   w_rdata = {24'b0, w_shift[7:0]};
            2'b01:   w_rdata = {16'b0, w_shift[15:0]};
            default: w_rdata = w_shift;
        endcase
    end

    always_comb begin
        w_next               = r_state;
        bus.ram_write_enable = 4'b0000;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    if (!w_legal) begin
                        w_next = RESP;
                    end else if (w_write) begin
                        w_next               = RESP;
                        bus.ram_write_enable = w_lanes;
                    end else begin
                        w_next = READ;
                    end
                end
            end
            READ:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_error      <= 1'b0;
            r_data0      <= '0;
            r_data1      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
                r_error      <= ~w_legal;
            end
            if (r_state == READ) begin
                if (r_grant)
                    r_data1 <= w_rdata;
                else
                    r_data0 <= w_rdata;
            end
        end
    end

    assign bus.ram_address = w_addr[AW-1:2];
    assign bus.ram_data_in = w_wdata;
    assign bus.r0_ack      = (r_state == RESP) && !r_grant;
    assign bus.r1_ack      = (r_state == RESP) && r_grant;
    assign bus.r0_error    = (r_state == RESP) && !r_grant && r_error;
    assign bus.r1_error    = (r_state == RESP) && r_grant && r_error;
    assign bus.r0_data_out = r_data0;
    assign bus.r1_data_out = r_data1;
endmodule
